seg7_scan_drv: RTL
==================

Name: seg7_scan_drv

Overview:
Display-side consumer of the 16-bit packed BCD bus produced by the LED/scroll effect blocks: four nibbles, 4'hF = blank digit. It time-multiplexes the four nibbles onto a common-anode 4-digit 7-segment display (digit enables, segments, decimal point). It snapshots the BCD bus once per scan frame so the display never tears mid-frame. It sits between the effect generator and the board's 7-segment pins.

Parameters:
REFRESH_DIV, 31250, clock cycles per digit slot (125 MHz -> 4 kHz digit rate, 1 kHz frame); legal range >= 1; benches use 4
SEG_ACTIVE_LOW, 1, 1 = seg/dp pins are driven low to light
AN_ACTIVE_LOW, 1, 1 = an pins are driven low to enable a digit

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
bcd  in  16  packed digits; [15:12] = leftmost digit, [3:0] = rightmost; 4'hF = blank
dp  in  4  decimal points; dp[3] = leftmost digit
en  in  1  1 = display on; 0 = all digits dark (scanning continues)
an  out  4  digit enables; an[3] = leftmost digit
seg  out  7  segments {g,f,e,d,c,b,a}
dp_o  out  1  decimal point of the currently enabled digit
frame_done  out  1  one-cycle pulse when a full 4-digit frame completes

Behaviour:
- Clock is clk; reset is synchronous, active-high, on rst.
- Reset (rst=1 at a rising edge): prescaler=0, sel=0, shadow_bcd=16'hFFFF, shadow_dp=4'h0, frame_done=0; an=all inactive (4'b1111 when AN_ACTIVE_LOW), seg=all off (7'h7F when SEG_ACTIVE_LOW), dp_o=off (1). Reset asserted mid-scan aborts the frame immediately; no frame_done.
- load_pending flag is set by reset. On the first edge with rst=0: shadow_bcd<=bcd, shadow_dp<=dp, load_pending<=0.
- Prescaler counts 0..REFRESH_DIV-1 and wraps; tick = (prescaler == REFRESH_DIV-1). REFRESH_DIV=1 gives a tick every cycle.
- sel (2 bits) selects the slot: 0 = leftmost (an[3], shadow_bcd[15:12]) ... 3 = rightmost (an[0], shadow_bcd[3:0]). On tick, sel increments and wraps 3 -> 0.
- Frame boundary = tick while sel==3. On that edge: sel<=0; shadow_bcd<=bcd; shadow_dp<=dp; frame_done<=1 for exactly that one cycle. Changes on bcd/dp at any other time are ignored until the next boundary.
- Output stage is registered: each edge, an/seg/dp_o load decode(sel, shadow) as they stand before the edge. Pins therefore lag sel and shadow by 1 cycle.
- Exactly one an bit is active when en=1 and rst=0. The first post-reset edge shows slot 0 with the reset shadow (blank). The second post-reset edge shows the real bcd[15:12].
- en=0: an all inactive, seg all off, dp_o off (registered, 1-cycle latency). Prescaler, sel, shadow and frame_done keep running.
- Logical segment codes (1 = lit) are given as hex {g..a}:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - A..E=40 (dash, out-of-range indicator)
  - F=00 (blank)
- A blank digit still asserts its anode, and its dp still follows shadow_dp.
- Pin value = logical value inverted when the matching *_ACTIVE_LOW=1.

Test Plan:
1. REFRESH_DIV=4, both polarities active-low, bcd=16'h25FF, dp=0, en=1; release rst.
   - Required: after 2 edges an=0111 seg=7'h24.
   - Then each 4 cycles: an=1011 seg=7'h12; an=1101 seg=7'h7F; an=1110 seg=7'h7F; back to an=0111.
   - frame_done pulses exactly once every 16 cycles.
2. Mid-frame update: during slot 1, change bcd to 16'hF25F.
   - Required: slots 2-3 still show the old frame (blank, blank).
   - The next frame shows blank, "2" (seg=7'h24), "5" (seg=7'h12), blank.
3. Code coverage: bcd=16'h0189, then 16'hABCD, dp=4'b1010.
   - Required: seg matches the decode table per slot (active-low): 0=40, 1=79, 8=00, 9=10; A..D=3F.
   - dp_o=0 on slots 0 and 2 only.
4. Set en=0 mid-slot.
   - Required: next edge an=1111, seg=7'h7F, dp_o=1; frame_done cadence unchanged.
   - Set en=1: scanning resumes in the current slot with no phase jump.
5. Assert rst for 1 cycle during slot 2.
   - Required: next edge an=1111, seg=7'h7F, no frame_done.
   - Scanning restarts at slot 0 with a blank first display cycle.
6. REFRESH_DIV=1 and SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=0, bcd=16'h25FF.
   - Required: an walks 1000, 0100, 0010, 0001 on consecutive cycles with seg=5B, 6D, 00, 00.
   - frame_done pulses every 4 cycles.

Source files
------------

// File: rtl/seg7_scan_drv.sv
// Four-digit 7-segment scan driver. It takes a 16-bit packed BCD word (4'hF = blank) and
// time-multiplexes it onto a common-anode display. The BCD and decimal-point inputs are
// snapshotted once per frame so that a frame never mixes old and new digits. The pins are
// driven from registers.
module seg7_scan_drv #(
  parameter int unsigned REFRESH_DIV    = 31250,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd,
  input  logic [3:0]  dp,
  input  logic        en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_o,
  output logic        frame_done
);

  localparam int unsigned PresW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PresW-1:0] PresMax = PresW'(REFRESH_DIV - 1);

  // Pin levels that mean "off"; a logical value is XOR-ed with these to get the pin value.
  localparam logic [3:0] AnOff  = {4{AN_ACTIVE_LOW}};
  localparam logic [6:0] SegOff = {7{SEG_ACTIVE_LOW}};
  localparam logic       DpOff  = SEG_ACTIVE_LOW;

  logic [PresW-1:0] prescaler_q;
  logic [1:0]       sel_q;
  logic [15:0]      shadow_bcd_q;
  logic [3:0]       shadow_dp_q;
  logic             load_pending_q;
  logic             frame_done_q;
  logic [3:0]       an_q;
  logic [6:0]       seg_q;
  logic             dp_q;

  logic       tick;
  logic       boundary;
  logic [3:0] nibble;
  logic       dp_sel;
  logic [3:0] an_log;
  logic [6:0] seg_log;
  logic [3:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;

  assign tick     = (prescaler_q == PresMax);
  assign boundary = tick && (sel_q == 2'd3);

  // Pick the slot's nibble, decimal point and anode. Slot 0 is the leftmost digit.
  always_comb begin
    nibble = 4'hF;
    dp_sel = 1'b0;
    an_log = 4'b0000;
    unique case (sel_q)
      2'd0: begin nibble = shadow_bcd_q[15:12]; dp_sel = shadow_dp_q[3]; an_log = 4'b1000; end
      2'd1: begin nibble = shadow_bcd_q[11:8];  dp_sel = shadow_dp_q[2]; an_log = 4'b0100; end
      2'd2: begin nibble = shadow_bcd_q[7:4];   dp_sel = shadow_dp_q[1]; an_log = 4'b0010; end
      2'd3: begin nibble = shadow_bcd_q[3:0];   dp_sel = shadow_dp_q[0]; an_log = 4'b0001; end
      default: ;
    endcase
  end

  // Decode the nibble to logical segments {g..a}. A..E show a dash and F shows a blank digit.
  always_comb begin
    seg_log = 7'h00;
    case (nibble)
      4'h0: seg_log = 7'h3F;
      4'h1: seg_log = 7'h06;
      4'h2: seg_log = 7'h5B;
      4'h3: seg_log = 7'h4F;
      4'h4: seg_log = 7'h66;
      4'h5: seg_log = 7'h6D;
      4'h6: seg_log = 7'h7D;
      4'h7: seg_log = 7'h07;
      4'h8: seg_log = 7'h7F;
      4'h9: seg_log = 7'h6F;
      4'hF: seg_log = 7'h00;
      default: seg_log = 7'h40;
    endcase
  end

  // Blank everything when the display is off, then map the logical values to pin polarity.
  always_comb begin
    an_d  = AnOff;
    seg_d = SegOff;
    dp_d  = DpOff;
    if (en) begin
      an_d  = an_log ^ AnOff;
      seg_d = seg_log ^ SegOff;
      dp_d  = dp_sel ^ DpOff;
    end
  end

  // Prescaler, slot select, frame snapshot and the registered pin stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_q    <= '0;
      sel_q          <= 2'd0;
      shadow_bcd_q   <= 16'hFFFF;
      shadow_dp_q    <= 4'h0;
      load_pending_q <= 1'b1;
      frame_done_q   <= 1'b0;
      an_q           <= AnOff;
      seg_q          <= SegOff;
      dp_q           <= DpOff;
    end else begin
      prescaler_q <= tick ? '0 : prescaler_q + PresW'(1);
      if (tick) begin
        sel_q <= sel_q + 2'd1;  // 3 wraps to 0 at the frame boundary
      end
      // Capture once right after reset and again at each frame boundary.
      if (boundary || load_pending_q) begin
        shadow_bcd_q <= bcd;
        shadow_dp_q  <= dp;
      end
      load_pending_q <= 1'b0;
      frame_done_q   <= boundary;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp_o       = dp_q;
  assign frame_done = frame_done_q;

endmodule
